wght_upd: RTL and testbench

WGHT_UPD -- requirements
Module: wght_upd

---
 rtl/wght_upd.sv | 168 ++++++++++++++++
 tb/tb_wght_upd.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wght_upd.sv
// wght_upd: a weight update engine for a small learned-parameter memory.
//
// One pass walks weights 0..n-1. For each weight it reads the accumulated
// gradient and the current weight, then writes back w - lr*grad. The weight
// is saturated to the signed WIDTH-bit range. Each weight takes three cycles
// (RD, EX, WR). One FIN cycle then pulses done and clears the gradient
// accumulators.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin a pass (only honoured while idle)
//   i_n        number of weights to update, clamped to 2^ADDR
//   i_lr       learning rate, signed Q(WIDTH-FRAC).FRAC
//   o_addr     shared read address (gradient bank and weight memory)
//   i_grad     gradient read data, valid one cycle after o_addr
//   i_wght     weight read data, valid one cycle after o_addr
//   o_we       weight write enable
//   o_waddr    weight write address
//   o_wdata    updated weight
//   o_acc_clr  one-cycle pulse clearing all gradient accumulators
//   o_busy     pass in progress
//   o_done     one-cycle pass-complete pulse
module wght_upd #(
    parameter int WIDTH = 24,
    parameter int FRAC  = 20,
    parameter int ADDR  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR:0]      i_n,
    input  logic [WIDTH-1:0]   i_lr,
    output logic [ADDR-1:0]    o_addr,
    input  logic [WIDTH-1:0]   i_grad,
    input  logic [WIDTH-1:0]   i_wght,
    output logic               o_we,
    output logic [ADDR-1:0]    o_waddr,
    output logic [WIDTH-1:0]   o_wdata,
    output logic               o_acc_clr,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic signed [WIDTH-1:0] W_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] W_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [ADDR:0]           N_MAX   = {1'b1, {ADDR{1'b0}}};
    localparam logic [ADDR:0]           N_ONE   = {{ADDR{1'b0}}, 1'b1};
    localparam logic [ADDR-1:0]         IDX_ONE = {{(ADDR-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, RD, EX, WR, FIN} state_t;

    state_t                   state;
    logic [ADDR-1:0]          idx;
    logic [ADDR:0]            n;
    logic signed [WIDTH-1:0]  lr;

    // Saturate a 2*WIDTH-bit value to WIDTH bits. The value fits only when
    // every bit above the WIDTH-bit sign position repeats the sign.
    function automatic logic signed [WIDTH-1:0] sat_prod(input logic signed [2*WIDTH-1:0] v);
        logic [WIDTH:0] top;
        top = v[2*WIDTH-1:WIDTH-1];
        if (top == {(WIDTH+1){1'b0}} || top == {(WIDTH+1){1'b1}})
            sat_prod = v[WIDTH-1:0];
        else if (v[2*WIDTH-1])
            sat_prod = W_MIN;
        else
            sat_prod = W_MAX;
    endfunction

    // Saturate a WIDTH+1-bit difference to WIDTH bits.
    function automatic logic signed [WIDTH-1:0] sat_diff(input logic signed [WIDTH:0] v);
        if (v[WIDTH] == v[WIDTH-1])
            sat_diff = v[WIDTH-1:0];
        else if (v[WIDTH])
            sat_diff = W_MIN;
        else
            sat_diff = W_MAX;
    endfunction

    // The update datapath. The memory read data is valid during EX, and the
    // result is captured straight into o_wdata at the EX->WR edge.
    logic signed [2*WIDTH-1:0] lr_x, grad_x, prod, shifted;
    logic signed [WIDTH-1:0]   wght_s, p_sat, upd;
    logic signed [WIDTH:0]     diff;

    always_comb begin
        lr_x    = {{WIDTH{lr[WIDTH-1]}}, lr};
        grad_x  = {{WIDTH{i_grad[WIDTH-1]}}, i_grad};
        wght_s  = i_wght;
        prod    = lr_x * grad_x;
        // An arithmetic shift floors toward -inf, so a small negative p stays -1.
        shifted = prod >>> FRAC;
        p_sat   = sat_prod(shifted);
        diff    = {wght_s[WIDTH-1], wght_s} - {p_sat[WIDTH-1], p_sat};
        upd     = sat_diff(diff);
    end

    // The FSM and the registered outputs. Each output is loaded on the edge
    // that enters the state decoding it. As a result, o_addr, o_waddr and
    // o_wdata keep their last values everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            n         <= '0;
            lr        <= '0;
            o_addr    <= '0;
            o_we      <= 1'b0;
            o_waddr   <= '0;
            o_wdata   <= '0;
            o_acc_clr <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_we      <= 1'b0;
            o_done    <= 1'b0;
            o_acc_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        o_busy <= 1'b1;
                        if (i_n != '0) begin
                            n      <= (i_n > N_MAX) ? N_MAX : i_n;
                            lr     <= i_lr;
                            idx    <= '0;
                            o_addr <= '0;
                            state  <= RD;
                        end else begin
                            o_done    <= 1'b1;
                            o_acc_clr <= 1'b1;
                            state     <= FIN;
                        end
                    end
                end
                RD: begin
                    state <= EX;
                end
                EX: begin
                    o_we    <= 1'b1;
                    o_waddr <= idx;
                    o_wdata <= upd;
                    state   <= WR;
                end
                WR: begin
                    if ({1'b0, idx} == n - N_ONE) begin
                        o_done    <= 1'b1;
                        o_acc_clr <= 1'b1;
                        state     <= FIN;
                    end else begin
                        idx    <= idx + IDX_ONE;
                        o_addr <= idx + IDX_ONE;
                        state  <= RD;
                    end
                end
                FIN: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wght_upd.sv
// tb_wght_upd: self-checking bench for wght_upd.
//
// The memory model is a pair of registered-read arrays. The bench uses a
// table of known update cases, randomized passes checked against a
// wide-integer arithmetic model, and hand-written reset/abort and
// zero-length sequences.
module tb_wght_upd;

    localparam int WIDTH = 24;
    localparam int FRAC  = 20;
    localparam int ADDR  = 5;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR:0]     i_n;
    logic [WIDTH-1:0]  i_lr;
    logic [ADDR-1:0]   o_addr;
    logic [WIDTH-1:0]  i_grad;
    logic [WIDTH-1:0]  i_wght;
    logic              o_we;
    logic [ADDR-1:0]   o_waddr;
    logic [WIDTH-1:0]  o_wdata;
    logic              o_acc_clr;
    logic              o_busy;
    logic              o_done;

    always #5 clk = ~clk;

    wght_upd #(.WIDTH(WIDTH), .FRAC(FRAC), .ADDR(ADDR)) dut (
        .clk(clk), .rst(rst), .start(start), .i_n(i_n), .i_lr(i_lr),
        .o_addr(o_addr), .i_grad(i_grad), .i_wght(i_wght),
        .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
        .o_acc_clr(o_acc_clr), .o_busy(o_busy), .o_done(o_done)
    );

    logic [WIDTH-1:0] grad_mem [DEPTH];
    logic [WIDTH-1:0] wght_mem [DEPTH];
    logic [WIDTH-1:0] exp_mem  [DEPTH];

    // Registered-read memories: data follows the address by one cycle.
    initial begin
        i_grad = '0;
        i_wght = '0;
    end
    always @(posedge clk) begin
        i_grad <= grad_mem[o_addr];
        i_wght <= wght_mem[o_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] outs();
        return {26'b0, o_addr, o_we, o_waddr, o_wdata, o_acc_clr, o_busy, o_done};
    endfunction

    // Reference update: plain integer arithmetic with floor shift and clamping.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] w,
                                              input logic [WIDTH-1:0] lr,
                                              input logic [WIDTH-1:0] g);
        longint wl, ll, gl, p, r;
        longint hi, lo;
        hi = 64'sd8388607;
        lo = -64'sd8388608;
        wl = longint'($signed(w));
        ll = longint'($signed(lr));
        gl = longint'($signed(g));
        p  = (ll * gl) >>> FRAC;
        if (p > hi) p = hi;
        if (p < lo) p = lo;
        r = wl - p;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r[WIDTH-1:0];
    endfunction

    // Run one pass and check every cycle against the expected timeline.
    // poke: cycle number in which start is pulsed again (0 = none).
    task automatic run_pass(input int n_in, input logic [WIDTH-1:0] lr, input int poke);
        int   nn, last;
        logic eb, ew, ef;
        nn = (n_in > DEPTH) ? DEPTH : n_in;
        last = (nn == 0) ? 1 : 3 * nn + 1;
        @(negedge clk);
        start = 1'b1;
        i_n   = 6'(n_in);
        i_lr  = lr;
        for (int k = 1; k <= last + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                i_n  = 6'($urandom);
                i_lr = 24'($urandom);
            end
            start = (k == poke);
            eb = (k <= last);
            ew = (nn > 0) && (k % 3 == 0) && (k <= 3 * nn);
            ef = (k == last);
            check("ctrl", {60'b0, o_busy, o_we, o_done, o_acc_clr}, {60'b0, eb, ew, ef, ef});
            if (ew)
                check("write", {35'b0, o_waddr, o_wdata}, {35'b0, 5'(k / 3 - 1), exp_mem[k / 3 - 1]});
            if (nn > 0 && k % 3 == 1 && k < last)
                check("raddr", {59'b0, o_addr}, {59'b0, 5'((k - 1) / 3)});
        end
        start = 1'b0;
    endtask

    task automatic randomize_mem(input int nn);
        for (int i = 0; i < DEPTH; i++) begin
            grad_mem[i] = 24'($urandom);
            wght_mem[i] = 24'($urandom);
        end
        for (int i = 0; i < DEPTH; i++)
            exp_mem[i] = 24'(nn);
    endtask

    typedef struct {
        int                    n;
        logic [WIDTH-1:0]      lr;
        logic [3:0][WIDTH-1:0] g;
        logic [3:0][WIDTH-1:0] w;
        logic [3:0][WIDTH-1:0] e;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [WIDTH-1:0] lr;
        int               nn;

        // Known cases: basic, both saturation directions, multi-weight, floor.
        tbl[0].n = 1; tbl[0].lr = 24'h080000;
        tbl[0].g = {72'h0, 24'h100000}; tbl[0].w = {72'h0, 24'h100000}; tbl[0].e = {72'h0, 24'h080000};
        tbl[1].n = 1; tbl[1].lr = 24'h100000;
        tbl[1].g = {72'h0, 24'h800000}; tbl[1].w = {72'h0, 24'h7FFFFF}; tbl[1].e = {72'h0, 24'h7FFFFF};
        tbl[2].n = 1; tbl[2].lr = 24'h100000;
        tbl[2].g = {72'h0, 24'h7FFFFF}; tbl[2].w = {72'h0, 24'h800000}; tbl[2].e = {72'h0, 24'h800000};
        tbl[3].n = 4; tbl[3].lr = 24'h100000;
        tbl[3].g = {24'h040000, 24'h030000, 24'h020000, 24'h010000};
        tbl[3].w = '0;
        tbl[3].e = {24'hFC0000, 24'hFD0000, 24'hFE0000, 24'hFF0000};
        tbl[4].n = 1; tbl[4].lr = 24'h000001;
        tbl[4].g = {72'h0, 24'hFFFFFF}; tbl[4].w = {72'h0, 24'h000000}; tbl[4].e = {72'h0, 24'h000001};

        rst   = 1'b1;
        start = 1'b0;
        i_n   = '0;
        i_lr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grad_mem[i] = '0;
            wght_mem[i] = '0;
            exp_mem[i]  = '0;
        end

        // Reset state, held and after release.
        repeat (3) @(negedge clk);
        check("reset_hold", outs(), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_release", outs(), 64'h0);

        // Table-driven cases; the multi-weight one also gets a start pulse in EX.
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 4; i++) begin
                grad_mem[i] = tbl[t].g[i];
                wght_mem[i] = tbl[t].w[i];
                exp_mem[i]  = tbl[t].e[i];
            end
            run_pass(tbl[t].n, tbl[t].lr, (t == 3) ? 2 : 0);
        end

        // Zero-length pass.
        run_pass(0, 24'h100000, 0);

        // Randomized passes, including the clamp boundaries.
        for (int r = 0; r < 24; r++) begin
            case (r)
                0:       nn = 32;
                1:       nn = 33;
                2:       nn = 63;
                default: nn = $urandom_range(1, 40);
            endcase
            if ($urandom_range(0, 1) == 1)
                lr = 24'($urandom);
            else
                lr = 24'($urandom_range(0, 24'h200000)) - 24'h100000;
            randomize_mem(nn);
            for (int i = 0; i < DEPTH; i++)
                exp_mem[i] = model(wght_mem[i], lr, grad_mem[i]);
            run_pass(nn, lr, (r % 5 == 4) ? 5 : 0);
        end

        // Abort: reset in the WR cycle of the second weight of a 4-weight pass.
        randomize_mem(4);
        @(negedge clk);
        start = 1'b1;
        i_n   = 6'd4;
        i_lr  = 24'h100000;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_in_wr", {58'b0, o_we, o_waddr}, {58'b0, 1'b1, 5'd1});
        rst = 1'b1;
        #1;
        check("abort_rst_outs", outs(), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("abort_quiet", outs(), 64'h0);
        end

        // A clean pass after the abort.
        lr = 24'h0C0000;
        for (int i = 0; i < DEPTH; i++)
            exp_mem[i] = model(wght_mem[i], lr, grad_mem[i]);
        run_pass(4, lr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
